// File: rtl/metro_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// metro_gate_ctrl_if
// Reader/actuator bundle for the metro gate controller.
//   master : reader front end / stimulus side; drives the code strobe, code,
//            pass sensor and maintenance override, and observes the gate status.
//   slave  : the gate controller; consumes the reader signals, drives the door
//            enable, deny pulse, lockout flag, fail counter and debug state.
// -----------------------------------------------------------------------------
interface metro_gate_ctrl_if #(
  parameter int CODE_W    = 4,
  parameter int MAX_FAILS = 3
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              validate_code;
  logic [CODE_W-1:0] access_code;
  logic              pass_sensor;
  logic              maint_open;
  logic              open_access_door;
  logic              deny_pulse;
  logic              locked_out;
  logic [FAIL_W-1:0] fail_count;
  logic [2:0]        state_out;

  modport master (
    output validate_code, access_code, pass_sensor, maint_open,
    input  open_access_door, deny_pulse, locked_out, fail_count, state_out
  );

  modport slave (
    input  validate_code, access_code, pass_sensor, maint_open,
    output open_access_door, deny_pulse, locked_out, fail_count, state_out
  );
endinterface

// File: rtl/metro_gate_ctrl.sv
// -----------------------------------------------------------------------------
// metro_gate_ctrl
// Access-gate controller: captures a presented code, range-checks it, holds the
// door open for a fixed time (closed early by the pass sensor), counts
// consecutive invalid attempts with a timed lockout, and supports a maintenance
// override that forces the door open.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   gate_bus : metro_gate_ctrl_if.slave
//              in  validate_code, access_code, pass_sensor, maint_open
//              out open_access_door, deny_pulse, locked_out, fail_count,
//                  state_out
// -----------------------------------------------------------------------------
module metro_gate_ctrl #(
  parameter int CODE_W         = 4,
  parameter int CODE_MIN       = 4,
  parameter int CODE_MAX       = 11,
  parameter int OPEN_CYCLES    = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 32
) (
  input logic              clk,
  input logic              rst_n,
  metro_gate_ctrl_if.slave gate_bus
);

  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CODE_W-1:0] MIN_CODE  = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] MAX_CODE  = CODE_W'(CODE_MAX);
  localparam logic [FAIL_W-1:0] FAIL_SAT  = FAIL_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_GRANTED = 3'd2,
    S_DENIED  = 3'd3,
    S_LOCKOUT = 3'd4,
    S_MAINT   = 3'd5
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [TMR_W-1:0]  r_timer,    w_timer_nxt;
  logic [CODE_W-1:0] r_code,     w_code_nxt;
  logic [FAIL_W-1:0] r_fail_cnt, w_fail_nxt;
  logic              w_code_ok;

  assign w_code_ok = (r_code >= MIN_CODE) && (r_code <= MAX_CODE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_code     <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_code     <= w_code_nxt;
      r_fail_cnt <= w_fail_nxt;
    end
  end

  // The timer defaults to zero, so it clears on every state change and only
  // advances in the branches that stay in GRANTED or LOCKOUT.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_code_nxt  = r_code;
    w_fail_nxt  = r_fail_cnt;

    if (gate_bus.maint_open) begin
      // Override wins over everything, including illegal encodings.
      w_state_nxt = S_MAINT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (gate_bus.validate_code) begin
            w_code_nxt  = gate_bus.access_code;
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_code_ok) begin
            w_state_nxt = S_GRANTED;
            w_fail_nxt  = '0;
          end else begin
            w_state_nxt = S_DENIED;
            w_fail_nxt  = (r_fail_cnt == FAIL_SAT) ? r_fail_cnt : r_fail_cnt + 1'b1;
          end
        end
        S_GRANTED: begin
          // Pass sensor outranks timer expiry; a code strobe here is dropped.
          if (gate_bus.pass_sensor || (r_timer == OPEN_LAST)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_DENIED: begin
          w_state_nxt = (r_fail_cnt == FAIL_SAT) ? S_LOCKOUT : S_IDLE;
        end
        S_LOCKOUT: begin
          if (r_timer == LOCK_LAST) begin
            w_state_nxt = S_IDLE;
            w_fail_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_MAINT: begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign gate_bus.open_access_door = (r_state == S_GRANTED) || (r_state == S_MAINT);
  assign gate_bus.deny_pulse       = (r_state == S_DENIED);
  assign gate_bus.locked_out       = (r_state == S_LOCKOUT);
  assign gate_bus.fail_count       = r_fail_cnt;
  assign gate_bus.state_out        = r_state;

endmodule

// File: tb/tb_metro_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_metro_gate_ctrl
// Two controller instances (default parameters, and an 8-bit code variant with
// window 100..200 and a 5-cycle door) share clock, reset and control stimulus.
// A behavioural model per instance tracks the gate as "phase + cycles left";
// outputs are compared against it on every falling edge. Directed scenarios add
// literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_metro_gate_ctrl;

  localparam int A_W = 4, A_MIN = 4, A_MAX = 11, A_OPEN = 16;
  localparam int B_W = 8, B_MIN = 100, B_MAX = 200, B_OPEN = 5;
  localparam int MF = 3, LOCK = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  metro_gate_ctrl_if #(.CODE_W(A_W), .MAX_FAILS(MF)) bus_a ();
  metro_gate_ctrl_if #(.CODE_W(B_W), .MAX_FAILS(MF)) bus_b ();

  metro_gate_ctrl #(
    .CODE_W(A_W), .CODE_MIN(A_MIN), .CODE_MAX(A_MAX), .OPEN_CYCLES(A_OPEN),
    .MAX_FAILS(MF), .LOCKOUT_CYCLES(LOCK)
  ) dut_a (.clk(clk), .rst_n(rst_n), .gate_bus(bus_a));

  metro_gate_ctrl #(
    .CODE_W(B_W), .CODE_MIN(B_MIN), .CODE_MAX(B_MAX), .OPEN_CYCLES(B_OPEN),
    .MAX_FAILS(MF), .LOCKOUT_CYCLES(LOCK)
  ) dut_b (.clk(clk), .rst_n(rst_n), .gate_bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: 0 idle, 1 checking, 2 door open, 3 denied, 4 locked, 5 maintenance.
  // left: cycles of the current timed phase still to run (including this one).
  typedef struct {
    int ph;
    int left;
    int code;
    int fails;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ph = 0; m.left = 0; m.code = 0; m.fails = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit v, input int code,
                                    input bit p, input bit mo,
                                    input int cmin, input int cmax, input int open_n);
    mdl_t n;
    n = m;
    if (mo) begin
      n.ph = 5;
      return n;
    end
    case (m.ph)
      0: if (v) begin n.code = code; n.ph = 1; end
      1: if (m.code >= cmin && m.code <= cmax) begin
           n.ph = 2; n.left = open_n; n.fails = 0;
         end else begin
           n.ph = 3; n.fails = (m.fails < MF) ? m.fails + 1 : MF;
         end
      2: if (p || m.left == 1) n.ph = 0; else n.left = m.left - 1;
      3: if (m.fails == MF) begin n.ph = 4; n.left = LOCK; end else n.ph = 0;
      4: if (m.left == 1) begin n.ph = 0; n.fails = 0; end else n.left = m.left - 1;
      default: begin n.ph = 0; n.fails = 0; end
    endcase
    return n;
  endfunction

  mdl_t m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= mdl_reset();
      m_b <= mdl_reset();
    end else begin
      m_a <= mdl_step(m_a, bus_a.validate_code, int'(bus_a.access_code), bus_a.pass_sensor,
                      bus_a.maint_open, A_MIN, A_MAX, A_OPEN);
      m_b <= mdl_step(m_b, bus_b.validate_code, int'(bus_b.access_code), bus_b.pass_sensor,
                      bus_b.maint_open, B_MIN, B_MAX, B_OPEN);
    end
  end

  task automatic cmp(input string tag, input mdl_t m, input logic door, input logic deny,
                     input logic lock, input logic [31:0] fc, input logic [2:0] st);
    check({tag, " state"}, 32'(st), 32'(m.ph));
    check({tag, " door"}, 32'(door), 32'(m.ph == 2 || m.ph == 5));
    check({tag, " deny"}, 32'(deny), 32'(m.ph == 3));
    check({tag, " locked"}, 32'(lock), 32'(m.ph == 4));
    check({tag, " fails"}, fc, 32'(m.fails));
  endtask

  always @(negedge clk) begin
    cmp("mdl A", m_a, bus_a.open_access_door, bus_a.deny_pulse, bus_a.locked_out,
        32'(bus_a.fail_count), bus_a.state_out);
    cmp("mdl B", m_b, bus_b.open_access_door, bus_b.deny_pulse, bus_b.locked_out,
        32'(bus_b.fail_count), bus_b.state_out);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] ca, input logic [7:0] cb,
                       input logic p, input logic mo);
    bus_a.validate_code = v;  bus_a.access_code = ca[A_W-1:0];
    bus_a.pass_sensor   = p;  bus_a.maint_open  = mo;
    bus_b.validate_code = v;  bus_b.access_code = cb;
    bus_b.pass_sensor   = p;  bus_b.maint_open  = mo;
  endtask

  // Strobes a code for one edge; returns on the falling edge after capture.
  task automatic present(input logic [7:0] ca, input logic [7:0] cb);
    @(negedge clk); drive(1'b1, ca, cb, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, ca, cb, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((bus_a.state_out != 3'd0 || bus_b.state_out != 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle reached"}, 32'(n < budget), 32'd1);
  endtask

  task automatic deny_code(input logic [7:0] ca, input logic [7:0] cb,
                           input int exp_fail, input int exp_next);
    present(ca, cb);
    @(negedge clk);
    check("deny state", 32'(bus_a.state_out), 32'd3);
    check("deny pulse", 32'(bus_a.deny_pulse), 32'd1);
    check("deny fails", 32'(bus_a.fail_count), 32'(exp_fail));
    @(negedge clk);
    check("deny next", 32'(bus_a.state_out), 32'(exp_next));
  endtask

  int bnd_a [4] = '{3, 4, 11, 12};
  int bnd_b [4] = '{99, 100, 200, 201};
  int bnd_e [4] = '{3, 2, 2, 3};

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, door_seen;
    logic v, p, mo;
    logic [7:0] ca, cb;

    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset door", 32'(bus_a.open_access_door), 32'd0);
    check("reset state", 32'(bus_a.state_out), 32'd0);
    check("reset locked", 32'(bus_a.locked_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: code 0 denied once
    present(8'd0, 8'd0);
    check("t1 check state", 32'(bus_a.state_out), 32'd1);
    @(negedge clk);
    check("t1 deny", 32'(bus_a.deny_pulse), 32'd1);
    check("t1 fails", 32'(bus_a.fail_count), 32'd1);
    check("t1 model fails", 32'(m_a.fails), 32'd1);
    check("t1 door", 32'(bus_a.open_access_door), 32'd0);
    @(negedge clk);
    check("t1 idle", 32'(bus_a.state_out), 32'd0);
    check("t1 deny drop", 32'(bus_a.deny_pulse), 32'd0);

    // 2: code 9 granted; door open 16 cycles (B: 150, 5 cycles)
    present(8'd9, 8'd150);
    check("t2 check state", 32'(bus_a.state_out), 32'd1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("t2 fails cleared", 32'(bus_a.fail_count), 32'd0);
      if (bus_a.open_access_door) cnt_a++;
      if (bus_b.open_access_door) cnt_b++;
    end
    check("t2 A open cycles", 32'(cnt_a), 32'd16);
    check("t2 B open cycles", 32'(cnt_b), 32'd5);
    check("t2 idle", 32'(bus_a.state_out), 32'd0);

    // 3: code 7, validate held while open, pass sensor on 5th open cycle
    present(8'd7, 8'd120);
    @(negedge clk);
    drive(1'b1, 8'd9, 8'd150, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t3 door before pass", 32'(bus_a.open_access_door), 32'd1);
    drive(1'b1, 8'd9, 8'd150, 1'b1, 1'b0);
    @(negedge clk);
    check("t3 door closed", 32'(bus_a.open_access_door), 32'd0);
    check("t3 idle", 32'(bus_a.state_out), 32'd0);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3 strobe dropped", 32'(bus_a.state_out), 32'd0);

    // 4: three invalid codes -> lockout 32 cycles
    deny_code(8'd0,  8'd0,   1, 0);
    deny_code(8'd12, 8'd99,  2, 0);
    deny_code(8'd15, 8'd201, 3, 4);
    cnt_a = 0; cnt_b = 0; door_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.locked_out) cnt_a++;
      if (bus_b.locked_out) cnt_b++;
      if (bus_a.open_access_door) door_seen++;
      if (i == 32) check("t4 exit strobe dropped", 32'(bus_a.state_out), 32'd0);
      drive((i == 4) || (i == 31), 8'd9, 8'd150, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("t4 A locked cycles", 32'(cnt_a), 32'd32);
    check("t4 B locked cycles", 32'(cnt_b), 32'd32);
    check("t4 door during lock", 32'(door_seen), 32'd0);
    check("t4 fails cleared", 32'(bus_a.fail_count), 32'd0);

    // 5: maintenance during lockout, then during granted
    deny_code(8'd0,  8'd0,   1, 0);
    deny_code(8'd12, 8'd99,  2, 0);
    deny_code(8'd15, 8'd201, 3, 4);
    repeat (3) @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("t5 maint state", 32'(bus_a.state_out), 32'd5);
    check("t5 maint door", 32'(bus_a.open_access_door), 32'd1);
    check("t5 maint unlocked", 32'(bus_a.locked_out), 32'd0);
    repeat (2) @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5 release idle", 32'(bus_a.state_out), 32'd0);
    check("t5 release fails", 32'(bus_a.fail_count), 32'd0);
    present(8'd9, 8'd150);
    repeat (2) @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("t5 maint from grant", 32'(bus_a.state_out), 32'd5);
    check("t5 maint door 2", 32'(bus_a.open_access_door), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5 release door", 32'(bus_a.open_access_door), 32'd0);
    check("t5 release idle 2", 32'(bus_a.state_out), 32'd0);

    // 6: boundary codes on both instances
    for (int k = 0; k < 4; k++) begin
      present(8'(bnd_a[k]), 8'(bnd_b[k]));
      @(negedge clk);
      check($sformatf("t6 A code %0d", bnd_a[k]), 32'(bus_a.state_out), 32'(bnd_e[k]));
      check($sformatf("t6 B code %0d", bnd_b[k]), 32'(bus_b.state_out), 32'(bnd_e[k]));
      wait_idle("t6", 40);
    end

    // reset in the middle of an open door
    present(8'd9, 8'd150);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst door A", 32'(bus_a.open_access_door), 32'd0);
    check("rst door B", 32'(bus_b.open_access_door), 32'd0);
    check("rst state A", 32'(bus_a.state_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized phase
    mo = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (mo) mo = ($urandom_range(0, 3) != 0);
      else    mo = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) == 0);
      ca = 8'($urandom_range(0, 15));
      cb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(95, 205)) : 8'($urandom_range(0, 255));
      p  = ($urandom_range(0, 9) == 0);
      drive(v, ca, cb, p, mo);
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/metro_gate_ctrl.md
Name: metro_gate_ctrl

Overview:
Parametrised next-generation metro access-gate controller. Captures a presented access code, range-checks it against a configurable window, then holds the door open for a configurable time; a pass-through sensor closes the door early. Adds invalid-attempt counting with timed lockout, a one-cycle deny indication, and a maintenance override. Sits between the ticket/card reader front end and the gate actuator driver.

Parameters:
CODE_W, 4, access code width in bits
CODE_MIN, 4, lowest valid code (inclusive)
CODE_MAX, 11, highest valid code (inclusive)
OPEN_CYCLES, 16, door-open hold time in clk cycles (>=1)
MAX_FAILS, 3, consecutive invalid codes that trigger lockout (>=1)
LOCKOUT_CYCLES, 32, lockout duration in clk cycles (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset
validate_code  input  1  code-present strobe from reader
access_code  input  CODE_W  code from reader, sampled with validate_code
pass_sensor  input  1  passenger passed through gate; closes door early
maint_open  input  1  maintenance override; forces door open while high
open_access_door  output  1  door actuator enable
deny_pulse  output  1  one-cycle invalid-code indication
locked_out  output  1  high during lockout
fail_count  output  $clog2(MAX_FAILS+1)  consecutive invalid attempts
state_out  output  3  current state encoding (debug)

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All registers clear: state=IDLE, timer=0, code register=0, fail_count=0. Outputs during and after reset: open_access_door=0, deny_pulse=0, locked_out=0, state_out=0.
- States and encodings: IDLE=0, CHECK=1, GRANTED=2, DENIED=3, LOCKOUT=4, MAINT=5. Encodings 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs are Moore, decoded combinationally from the state register:
  - open_access_door=1 in GRANTED and MAINT.
  - deny_pulse=1 in DENIED.
  - locked_out=1 in LOCKOUT.
- IDLE: if validate_code=1 at an edge, latch access_code into the code register and go to CHECK.
- CHECK (exactly one cycle):
  - If CODE_MIN <= latched code <= CODE_MAX (unsigned): go to GRANTED and clear fail_count.
  - Otherwise: go to DENIED and increment fail_count (saturates at MAX_FAILS).
  - access_code changes after capture are ignored.
- GRANTED:
  - timer counts 0,1,2,…
  - Go to IDLE on the edge where timer==OPEN_CYCLES-1, so the door is open exactly OPEN_CYCLES cycles.
  - pass_sensor=1 at any edge in GRANTED gives IDLE at that edge (early close).
  - validate_code is ignored in GRANTED.
- DENIED (one cycle): go to LOCKOUT if fail_count==MAX_FAILS, else go to IDLE.
- LOCKOUT:
  - timer counts; at timer==LOCKOUT_CYCLES-1 go to IDLE and clear fail_count.
  - validate_code is ignored for the whole lockout.
- Timer: width $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)+1). Cleared on every state change; increments only in GRANTED and LOCKOUT.
- MAINT:
  - maint_open=1 has highest priority: from any state, next state is MAINT.
  - When maint_open falls: go to IDLE; timer and fail_count cleared.
  - Lockout and GRANTED are aborted on entry to MAINT.
- Simultaneous events, in priority order:
  - maint_open > pass_sensor > timer expiry.
  - validate_code in the same cycle as leaving GRANTED or LOCKOUT is dropped; the reader must re-present the code.
- Reset mid-operation: door closes immediately (asynchronous) and the fail history is lost.

Test Plan:
1. Reset, then validate_code=1 with code=0 → CHECK, DENIED; deny_pulse high 1 cycle; fail_count=1; door stays 0; back to IDLE.
2. Present code=9 → one CHECK cycle, then open_access_door=1 for exactly 16 cycles; state_out 1→2→0; fail_count cleared to 0.
3. Code=7 granted; pass_sensor=1 on the 5th GRANTED cycle → door closes at that edge, IDLE; a validate_code held during GRANTED is ignored.
4. Three invalid codes (0, 12, 15) → third DENIED goes to LOCKOUT; locked_out=1 for 32 cycles; a code=9 presented during lockout is ignored; exit with fail_count=0.
5. maint_open=1 during LOCKOUT and during GRANTED → MAINT next edge, door=1, locked_out=0; release → IDLE, fail_count=0.
6. Boundary codes 3, 4, 11, 12 → 4 and 11 granted; 3 and 12 denied. Assert rst_n low mid-GRANTED → door 0 immediately, state_out=0. Re-run with CODE_W=8, CODE_MIN=100, CODE_MAX=200, OPEN_CYCLES=5.
